// File: rtl/microroc_sc_loader.sv
// Slow-control loader for the MICROROC chain: serialises {DAC2, DAC1, DAC0} MSB first
// on SrCk/SrIn and compares the chain tail against the previously loaded frame.
module microroc_sc_loader #(
  parameter int DAC_WIDTH     = 10,
  parameter int HALF_PERIOD   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 LoadSCParameter,
  input  logic [DAC_WIDTH-1:0] OutDAC0,
  input  logic [DAC_WIDTH-1:0] OutDAC1,
  input  logic [DAC_WIDTH-1:0] OutDAC2,
  output logic                 MicrorocConfigDone,
  output logic                 SCBusy,
  output logic                 ReadbackError,
  output logic                 SrCk,
  output logic                 SrIn,
  input  logic                 SrOut
);
  localparam int FRAME = 3 * DAC_WIDTH;
  localparam int BW    = $clog2(FRAME + 1);
  localparam int PW    = $clog2(2 * HALF_PERIOD);
  localparam int SW    = $clog2(SETTLE_CYCLES + 1);

  localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME - 1);
  localparam logic [PW-1:0] PH_RISE    = PW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] PH_LAST    = PW'(2 * HALF_PERIOD - 1);
  localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, SETTLE, DONE} state_t;

  state_t           state;
  logic [FRAME-1:0] shift_reg;
  logic [FRAME-1:0] frame_reg;
  logic [FRAME-1:0] prev_frame;
  logic [FRAME-1:0] prev_shift;
  logic [BW-1:0]    bit_cnt;
  logic [PW-1:0]    phase;
  logic [SW-1:0]    settle_cnt;
  logic             mismatch;
  logic             prev_valid;
  logic [FRAME-1:0] new_frame;

  assign new_frame = {OutDAC2, OutDAC1, OutDAC0};

  // Outputs are registered from the state being entered, so SrCk/SrIn line up with phase.
  // SrOut is sampled on the edge where SrCk rises, i.e. before the ASIC chain shifts.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state              <= IDLE;
      shift_reg          <= '0;
      frame_reg          <= '0;
      prev_frame         <= '0;
      prev_shift         <= '0;
      bit_cnt            <= '0;
      phase              <= '0;
      settle_cnt         <= '0;
      mismatch           <= 1'b0;
      prev_valid         <= 1'b0;
      MicrorocConfigDone <= 1'b0;
      SCBusy             <= 1'b0;
      ReadbackError      <= 1'b0;
      SrCk               <= 1'b0;
      SrIn               <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          MicrorocConfigDone <= 1'b0;
          if (LoadSCParameter) begin
            shift_reg  <= new_frame;
            frame_reg  <= new_frame;
            prev_shift <= prev_frame;
            bit_cnt    <= '0;
            phase      <= '0;
            mismatch   <= 1'b0;
            SCBusy     <= 1'b1;
            SrCk       <= 1'b0;
            SrIn       <= new_frame[FRAME-1];
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (phase == PH_RISE && SrOut != prev_shift[FRAME-1]) mismatch <= 1'b1;
          if (phase == PH_LAST) begin
            phase      <= '0;
            SrCk       <= 1'b0;
            shift_reg  <= shift_reg << 1;
            prev_shift <= prev_shift << 1;
            bit_cnt    <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              SrIn       <= 1'b0;
              settle_cnt <= '0;
              state      <= SETTLE;
            end else begin
              SrIn <= shift_reg[FRAME-2];
            end
          end else begin
            phase <= phase + 1'b1;
            SrCk  <= (phase >= PH_RISE);
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_END) begin
            MicrorocConfigDone <= 1'b1;
            ReadbackError      <= mismatch & prev_valid;
            prev_frame         <= frame_reg;
            prev_valid         <= 1'b1;
            state              <= DONE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        DONE: begin
          MicrorocConfigDone <= 1'b0;
          SCBusy             <= 1'b0;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_microroc_sc_loader.sv
// Bench for microroc_sc_loader: a default instance and a fast (HALF_PERIOD=1) instance
// are predicted cycle by cycle from the load start offset, each with a model ASIC chain.
module tb_microroc_sc_loader;
  localparam int DW    = 10;
  localparam int FRAME = 3 * DW;

  logic          Clk = 1'b0;
  logic          reset;
  logic          LoadSCParameter;
  logic [DW-1:0] OutDAC0, OutDAC1, OutDAC2;
  logic [1:0]    done, busy, rbErr, srCk, srIn, srOut;
  logic          forceTail;
  logic          checking;

  logic [FRAME-1:0] chain0 = '0;
  logic [FRAME-1:0] chain1 = '0;

  int nCmp = 0;
  int nBad = 0;
  int ecount = 0;

  // Reference model state, one slot per instance.
  bit               mAct[2];
  int               mT[2];
  int               mCap[2];
  logic [FRAME-1:0] mFrame[2];
  logic [FRAME-1:0] mPrev[2];
  bit               mPv[2];
  bit               mRb[2];
  bit               mErr[2];

  int               rises[2];
  logic [FRAME-1:0] stream[2];
  logic [1:0]       lastCk = 2'b00;

  int               cT, cTp, cSh;
  logic             eBusy, eDone, eCk, eIn;

  always #5 Clk = ~Clk;

  microroc_sc_loader dut (
    .Clk(Clk), .reset(reset), .LoadSCParameter(LoadSCParameter),
    .OutDAC0(OutDAC0), .OutDAC1(OutDAC1), .OutDAC2(OutDAC2),
    .MicrorocConfigDone(done[0]), .SCBusy(busy[0]), .ReadbackError(rbErr[0]),
    .SrCk(srCk[0]), .SrIn(srIn[0]), .SrOut(srOut[0])
  );

  microroc_sc_loader #(.DAC_WIDTH(DW), .HALF_PERIOD(1), .SETTLE_CYCLES(1)) dutFast (
    .Clk(Clk), .reset(reset), .LoadSCParameter(LoadSCParameter),
    .OutDAC0(OutDAC0), .OutDAC1(OutDAC1), .OutDAC2(OutDAC2),
    .MicrorocConfigDone(done[1]), .SCBusy(busy[1]), .ReadbackError(rbErr[1]),
    .SrCk(srCk[1]), .SrIn(srIn[1]), .SrOut(srOut[1])
  );

  // Model ASIC chains: SrIn enters at bit 0, the tail drives SrOut.
  always @(posedge srCk[0]) chain0 <= {chain0[FRAME-2:0], srIn[0]};
  always @(posedge srCk[1]) chain1 <= {chain1[FRAME-2:0], srIn[1]};
  assign srOut[0] = forceTail ? 1'b1 : chain0[FRAME-1];
  assign srOut[1] = chain1[FRAME-1];

  function automatic int shLen(input int k);
    return (k == 0) ? FRAME * 4 : FRAME * 2;
  endfunction

  function automatic int totLen(input int k);
    return shLen(k) + ((k == 0) ? 4 : 1) + 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      if (nBad <= 40)
        $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, ecount);
    end
  endtask

  // Model: tracks each load by its cycle offset from the capture edge.
  always @(posedge Clk) begin
    ecount++;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mAct[k] = 0;
        mPv[k]  = 0;
        mRb[k]  = 0;
        mPrev[k] = '0;
      end else if (mAct[k]) begin
        mT[k]++;
        if (mT[k] == totLen(k)) begin
          mRb[k]   = mPv[k] && mErr[k];
          mPrev[k] = mFrame[k];
          mPv[k]   = 1;
        end
        if (mT[k] > totLen(k)) mAct[k] = 0;
      end else if (LoadSCParameter) begin
        mAct[k]   = 1;
        mT[k]     = 1;
        mCap[k]   = ecount;
        mFrame[k] = {OutDAC2, OutDAC1, OutDAC0};
        mErr[k]   = (k == 0 && forceTail) ? (mPrev[k] != '1) : 1'b0;
      end
    end
  end

  // Compare every output of both instances against the model on each falling edge.
  always @(negedge Clk) begin
    if (checking) begin
      for (int k = 0; k < 2; k++) begin
        cSh = shLen(k);
        cTp = (k == 0) ? 4 : 2;
        eBusy = 0; eDone = 0; eCk = 0; eIn = 0;
        if (mAct[k]) begin
          cT    = mT[k];
          eBusy = 1;
          eDone = (cT == totLen(k));
          eCk   = (cT <= cSh) && (((cT - 1) % cTp) >= cTp / 2);
          eIn   = (cT <= cSh) ? mFrame[k][FRAME - 1 - (cT - 1) / cTp] : 1'b0;
          if (cT == 1) begin
            rises[k]  = 0;
            stream[k] = '0;
          end
        end
        checkOutput($sformatf("busy%0d", k), busy[k], eBusy);
        checkOutput($sformatf("done%0d", k), done[k], eDone);
        checkOutput($sformatf("srck%0d", k), srCk[k], eCk);
        checkOutput($sformatf("srin%0d", k), srIn[k], eIn);
        checkOutput($sformatf("rberr%0d", k), rbErr[k], mRb[k]);
        if (srCk[k] === 1'b1 && lastCk[k] == 1'b0) begin
          rises[k]++;
          stream[k] = {stream[k][FRAME-2:0], srIn[k]};
        end
        lastCk[k] = srCk[k];
        if (done[k] === 1'b1 && mAct[k]) begin
          checkOutput($sformatf("latency%0d", k), ecount - mCap[k] + 1, (k == 0) ? 125 : 62);
          checkOutput($sformatf("rises%0d", k), rises[k], 30);
        end
      end
    end
  end

  // Drives one request cycle, then scrambles the DAC inputs while the load is in flight.
  task automatic applyStimulus(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                               input logic [DW-1:0] d2);
    @(posedge Clk); #2;
    OutDAC0 = d0; OutDAC1 = d1; OutDAC2 = d2;
    LoadSCParameter = 1'b1;
    @(posedge Clk); #2;
    LoadSCParameter = 1'b0;
    OutDAC0 = DW'($urandom); OutDAC1 = DW'($urandom); OutDAC2 = DW'($urandom);
  endtask

  task automatic waitDone(input int lim, output int doneAt);
    int i = 0;
    @(negedge Clk);
    while (done[0] !== 1'b1 && i < lim) begin
      @(negedge Clk);
      i++;
    end
    checkOutput("done_seen", {31'd0, done[0] === 1'b1}, 1);
    doneAt = ecount;
  endtask

  initial begin
    int doneAt, prevDone, capE, extra;
    logic [DW-1:0] d1, d2;
    reset = 1'b1; LoadSCParameter = 1'b0; forceTail = 1'b0; checking = 1'b0;
    OutDAC0 = '0; OutDAC1 = '0; OutDAC2 = '0;
    prevDone = 0;
    repeat (3) @(posedge Clk);
    #2 checking = 1'b1;
    @(posedge Clk); #2 reset = 1'b0;
    @(negedge Clk);
    checkOutput("reset_busy", busy[0], 0);
    checkOutput("reset_done", done[0], 0);
    checkOutput("reset_rberr", rbErr[0], 0);
    checkOutput("reset_srck", srCk[0], 0);
    checkOutput("reset_srin", srIn[0], 0);

    // First load after reset: DAC0 = 500.
    applyStimulus(DW'(500), '0, '0);
    capE = ecount;
    waitDone(200, doneAt);
    checkOutput("model_frame", mFrame[0], 32'd500);
    checkOutput("stream_500", stream[0], 32'b000000000000000000000111110100);
    checkOutput("first_latency", doneAt - capE + 1, 125);
    checkOutput("first_rberr", rbErr[0], 0);

    // DAC0 sweep with back-to-back requests.
    d1 = DW'($urandom); d2 = DW'($urandom);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(DW'(500 + i), d1, d2);
      waitDone(200, doneAt);
      checkOutput("sweep_rberr", rbErr[0], 0);
      if (i > 0) checkOutput("sweep_spacing", doneAt - prevDone, 126);
      prevDone = doneAt;
    end

    // Same sweep with the chain tail stuck at 1 during the third load.
    for (int i = 0; i < 6; i++) begin
      forceTail = (i == 2);
      applyStimulus(DW'(500 + i), d1, d2);
      waitDone(200, doneAt);
      forceTail = 1'b0;
      if (i == 2) checkOutput("forced_rberr", rbErr[0], 1);
      if (i == 3) checkOutput("recover_rberr", rbErr[0], 0);
    end

    // Requests re-pulsed at cycles 10 and 124 of a load are ignored.
    applyStimulus(DW'(123), DW'(456), DW'(789));
    capE = ecount;
    repeat (9) @(posedge Clk);
    #2 LoadSCParameter = 1'b1;
    @(posedge Clk); #2 LoadSCParameter = 1'b0;
    repeat (113) @(posedge Clk);
    #2 LoadSCParameter = 1'b1;
    @(posedge Clk); #2 LoadSCParameter = 1'b0;
    waitDone(100, doneAt);
    checkOutput("repulse_latency", doneAt - capE + 1, 125);
    extra = 0;
    repeat (130) begin
      @(negedge Clk);
      if (done[0] === 1'b1) extra++;
    end
    checkOutput("repulse_extra_done", extra, 0);

    // Reset in SHIFT cycle 60 aborts the load and clears PrevValid.
    applyStimulus(DW'(321), DW'(654), DW'(987));
    repeat (59) @(posedge Clk);
    #2 reset = 1'b1;
    @(posedge Clk); #2 reset = 1'b0;
    @(negedge Clk);
    checkOutput("abort_busy", busy[0], 0);
    checkOutput("abort_done", done[0], 0);
    checkOutput("abort_srck", srCk[0], 0);
    checkOutput("abort_srin", srIn[0], 0);
    repeat (5) @(posedge Clk);
    applyStimulus(DW'($urandom), DW'($urandom), DW'($urandom));
    waitDone(200, doneAt);
    checkOutput("post_reset_rberr", rbErr[0], 0);

    // Random requests, DAC churn and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge Clk); #2;
      LoadSCParameter = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 599) == 0);
      OutDAC0 = DW'($urandom); OutDAC1 = DW'($urandom); OutDAC2 = DW'($urandom);
    end
    @(posedge Clk); #2;
    LoadSCParameter = 1'b0;
    reset = 1'b0;
    repeat (200) @(posedge Clk);
    @(negedge Clk);
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule

// File: doc/microroc_sc_loader.md
# microroc_sc_loader

Slow-control loader for the MICROROC configuration chain. It is the responder to the sweep controller's `LoadSCParameter` / `MicrorocConfigDone` handshake. It captures the requested DAC codes, shifts them serially into the ASIC shift register, and checks the bits that fall out of the chain against the previously loaded frame. It then returns a single-cycle done pulse, which lets the sweep controller move on to the next DAC step.

## Interface
Parameters:
- `DAC_WIDTH`, 10: width of each DAC code.
- `HALF_PERIOD`, 2: `Clk` cycles per `SrCk` half-period (≥1).
- `SETTLE_CYCLES`, 4: cycles idled after the last bit before done (≥1).

Ports:
- `Clk` input 1: system clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `LoadSCParameter` input 1: load request; sampled only in IDLE.
- `OutDAC0` input DAC_WIDTH: DAC0 code (sweep value).
- `OutDAC1` input DAC_WIDTH: DAC1 code.
- `OutDAC2` input DAC_WIDTH: DAC2 code.
- `MicrorocConfigDone` output 1: one-cycle pulse, load complete.
- `SCBusy` output 1: high from capture through the done cycle.
- `ReadbackError` output 1: result of the last readback compare.
- `SrCk` output 1: serial shift clock to the ASIC.
- `SrIn` output 1: serial data to the ASIC.
- `SrOut` input 1: serial data out of the ASIC chain tail.

## Operation
- Frame: FRAME = 3·DAC_WIDTH bits, {OutDAC2, OutDAC1, OutDAC0}, shifted MSB first (OutDAC2[MSB] first, OutDAC0[0] last).
- States: IDLE, SHIFT, SETTLE, DONE.
- IDLE:
  - `LoadSCParameter`=1 → capture frame into shift register, clear bit counter and phase counter, clear mismatch accumulator, go to SHIFT.
  - `LoadSCParameter`=0 → stay.
- SHIFT:
  - Each bit lasts 2·HALF_PERIOD cycles (phase 0 … 2·HALF_PERIOD−1).
  - `SrIn` = shift-register MSB for the whole bit.
  - `SrCk` = 1 for phases HALF_PERIOD … 2·HALF_PERIOD−1, else 0.
  - At phase HALF_PERIOD (the edge `SrCk` rises), `SrOut` is sampled. The sample is compared with bit i of the previous frame (same MSB-first order). Any difference sets the mismatch accumulator.
  - At the last phase, shift left by one and increment the bit counter.
  - After bit FRAME−1 → SETTLE.
- SETTLE: `SrCk`=0, `SrIn`=0 for SETTLE_CYCLES cycles → DONE.
- DONE, one cycle:
  - `MicrorocConfigDone`=1.
  - `ReadbackError` = mismatch accumulator AND PrevValid.
  - PrevFrame ← captured frame; PrevValid ← 1.
  - → IDLE.
- `ReadbackError` holds its value until the next DONE. The first load after reset always reports 0.
- `LoadSCParameter` asserted outside IDLE is ignored: no queuing, no restart.
- DAC input changes after capture do not affect the frame in flight.
- Arithmetic:
  - Bit counter is sized ceil(log2(FRAME+1)).
  - Phase counter is sized ceil(log2(2·HALF_PERIOD)).
  - Both wrap only under FSM control, never free-running.

## Timing
- Reset values: `MicrorocConfigDone`=0, `SCBusy`=0, `ReadbackError`=0, `SrCk`=0, `SrIn`=0.
  - Also: PrevValid=0, PrevFrame=0, state IDLE.
- Reset is synchronous and wins over everything. Asserted mid-SHIFT or SETTLE, it returns all outputs to reset values at the next edge with no done pulse. PrevValid is cleared.
- All outputs are registered.
- With `LoadSCParameter` sampled high at edge 0:
  - `SCBusy` rises at edge 1.
  - SHIFT occupies cycles 1 … FRAME·2·HALF_PERIOD.
  - SETTLE occupies the next SETTLE_CYCLES cycles.
  - `MicrorocConfigDone` is high in cycle FRAME·2·HALF_PERIOD + SETTLE_CYCLES + 1. Defaults: cycle 125.
- `SCBusy` falls the cycle after DONE. A request in that cycle is accepted, so back-to-back loads are spaced exactly 126 cycles with defaults.
- `SrIn` is stable for HALF_PERIOD cycles before and during each `SrCk` high phase.
- `SrCk` high time = low time = HALF_PERIOD cycles. Exactly FRAME rising edges per load.

## Test plan
- Reset, then one pulse with DAC0=500, DAC1=0, DAC2=0:
  - `SrIn` bit stream is 20 zeros then 0b0111110100 MSB first.
  - Exactly 30 `SrCk` rises.
  - Done pulse in cycle 125.
  - `ReadbackError`=0.
- Sweep DAC0 500→505 with a model chain (30-bit shift register clocked by `SrCk`, tail to `SrOut`):
  - Six done pulses 126 cycles apart when requests are issued on the cycle `SCBusy` falls.
  - `ReadbackError`=0 on every pulse.
- Same sweep with the model's tail bit forced to 1 during load 3:
  - `ReadbackError`=1 after load 3.
  - `ReadbackError` returns to 0 after load 4.
- `LoadSCParameter` re-pulsed at cycles 10 and 124 of a load:
  - Ignored.
  - Still exactly one done pulse and 30 `SrCk` rises.
- `reset` asserted in SHIFT cycle 60:
  - Next edge: all outputs 0, no done pulse.
  - A new load completes and reports `ReadbackError`=0, because PrevValid was cleared.
- HALF_PERIOD=1, SETTLE_CYCLES=1:
  - Done pulse in cycle 62.
  - `SrCk` toggles every cycle during SHIFT.
